// File: rtl/c17_mon_pkg.sv
// Shared types and defaults for the c17 toggle monitor.
// The state encoding is visible to the top and to anything that probes it.
package c17_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int CNT_W_DEF = 16;
   localparam int WIN_W_DEF = 16;
   localparam int NUM_OUT   = 2;   // nx22, nx23

endpackage

// File: rtl/c17_sync_edge.sv
// Synchroniser chain plus one history flop; flags any level change of d.
// The history always tracks the synchronised level, so it never holds a stale value.
module c17_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic edge_det
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level    = sync_q[SYNC_STAGES-1];
   assign edge_det = level ^ hist_q;

endmodule

// File: rtl/c17_toggle_monitor.sv
// Counts toggles of the asynchronous c17 outputs nx22/nx23 over a programmable
// window, reporting through a start/busy/done handshake.
module c17_toggle_monitor
   import c17_mon_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int WIN_W       = WIN_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIN_W-1:0] window_len,
   input  logic             nx22,
   input  logic             nx23,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] tgl22,
   output logic [CNT_W-1:0] tgl23,
   output logic             ovf22,
   output logic             ovf23
);

   state_e                             state_q, state_d;
   logic [WIN_W-1:0]                   rem_q, rem_d;
   logic [NUM_OUT-1:0]                 nx_in;
   logic [NUM_OUT-1:0]                 edge_det;
   logic [NUM_OUT-1:0][CNT_W-1:0]      cnt_q;
   logic [NUM_OUT-1:0]                 ovf_q;

   assign nx_in = {nx23, nx22};

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
      c17_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk      (clk),
         .rst      (rst),
         .d        (nx_in[i]),
         .level    (),
         .edge_det (edge_det[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // COUNT exits when remaining hits 1, so it lasts exactly window_len cycles.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               rem_d   = window_len;
            end
         end
         CLEAR: state_d = (rem_q == '0) ? DONE : COUNT;
         COUNT: begin
            if (rem_q == WIN_W'(1)) state_d = DONE;
            else                    rem_d   = rem_q - WIN_W'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Edges outside COUNT are dropped; a full counter holds and flags overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= '0;
      end else if (state_q == CLEAR) begin
         cnt_q <= '0;
         ovf_q <= '0;
      end else if (state_q == COUNT) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (edge_det[i]) begin
               if (&cnt_q[i]) ovf_q[i] <= 1'b1;
               else           cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign tgl22 = cnt_q[0];
   assign tgl23 = cnt_q[1];
   assign ovf22 = ovf_q[0];
   assign ovf23 = ovf_q[1];

endmodule
